// File: rtl/gtwizard_reset_pkg.sv
// ============================================================================
// Module      : gtwizard_reset_pkg
// Description : Shared state encodings, constants and counter sizing helper
//               for the common PLL reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gtwizard_reset_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_INIT_WAIT    = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ASSERT_RESET = 3'd1;
    localparam logic [c_STATE_W-1:0] c_WAIT_LOCK    = 3'd2;
    localparam logic [c_STATE_W-1:0] c_READY        = 3'd3;
    localparam logic [c_STATE_W-1:0] c_FAIL         = 3'd4;

    localparam int c_BLANK_CYCLES = 2;
    localparam int c_SYNC_STAGES  = 2;
    localparam int c_RETRY_W      = 4;
    localparam int c_RETRY_MAX    = 15;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gtwizard_lock_sync.sv
// ============================================================================
// Module      : gtwizard_lock_sync
// Description : Two-flop synchroniser for a vector of independent PLL lock
//               indicators. Used only when LOCK_SYNC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gtwizard_lock_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta = '0;
    logic [WIDTH-1:0] r_sync = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/gtwizard_common_reset_seq.sv
// ============================================================================
// Module      : gtwizard_common_reset_seq
// Description : Post-configuration reset and lock-retry sequencer for the
//               common PLLs. Define LOCK_SYNC_EN to synchronise PLL_LOCK.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gtwizard_common_reset_seq
    import gtwizard_reset_pkg::*;
#(
    parameter int STABLE_CLOCK_PERIOD = 8,
    parameter int NUM_PLL             = 2,
    parameter int STARTUP_DELAY       = 500,
    parameter int RESET_PULSE_CYCLES  = 4,
    parameter int LOCK_TIMEOUT_CYCLES = 1000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               STABLE_CLOCK,
    input  logic               SOFT_RESET_N,
    input  logic [NUM_PLL-1:0] PLL_LOCK,
    output logic [NUM_PLL-1:0] COMMON_RESET,
    output logic               PLL_READY,
    output logic               RESET_FAIL,
    output logic [3:0]         RETRY_COUNT
);

    localparam int c_WAIT_MAX = STARTUP_DELAY / STABLE_CLOCK_PERIOD + 10;
    localparam int c_WAIT_W   = cnt_width(c_WAIT_MAX);

`ifdef LOCK_SYNC_EN
    localparam int c_LOCK_LAT = c_SYNC_STAGES;
`else
    localparam int c_LOCK_LAT = 0;
`endif

    // Lock is accepted from the entry clock plus BLANK-1 clocks onward; any
    // synchroniser depth extends the window so stale pre-pulse lock is flushed.
    localparam int c_HOLDOFF   = c_BLANK_CYCLES - 1 + c_LOCK_LAT;
    localparam int c_PHASE_MAX = (RESET_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES)
                                 ? ((RESET_PULSE_CYCLES > c_HOLDOFF) ? RESET_PULSE_CYCLES : c_HOLDOFF)
                                 : ((LOCK_TIMEOUT_CYCLES > c_HOLDOFF) ? LOCK_TIMEOUT_CYCLES : c_HOLDOFF);
    localparam int c_PHASE_W   = cnt_width(c_PHASE_MAX);

    localparam logic [c_WAIT_W-1:0]  c_WAIT_END    = c_WAIT_W'(c_WAIT_MAX);
    localparam logic [c_PHASE_W-1:0] c_PULSE_END   = c_PHASE_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [c_PHASE_W-1:0] c_TIMEOUT_END = c_PHASE_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_PHASE_W-1:0] c_HOLDOFF_V   = c_PHASE_W'(c_HOLDOFF);
    localparam logic [c_RETRY_W-1:0] c_RETRY_LIMIT = c_RETRY_W'(MAX_RETRIES);
    localparam logic [c_RETRY_W-1:0] c_RETRY_SAT   = c_RETRY_W'(c_RETRY_MAX);

    logic [c_STATE_W-1:0] r_state        = c_INIT_WAIT;
    logic [c_WAIT_W-1:0]  r_wait_cnt     = '0;
    logic [c_PHASE_W-1:0] r_phase_cnt    = '0;
    logic [c_RETRY_W-1:0] r_retry_cnt    = '0;
    logic                 r_common_reset = 1'b0;
    logic                 r_pll_ready    = 1'b0;
    logic                 r_reset_fail   = 1'b0;

    logic [c_STATE_W-1:0] w_state_nxt;
    logic [c_WAIT_W-1:0]  w_wait_cnt_nxt;
    logic [c_PHASE_W-1:0] w_phase_cnt_nxt;
    logic [c_RETRY_W-1:0] w_retry_cnt_nxt;
    logic [c_RETRY_W-1:0] w_retry_inc;
    logic                 w_common_reset_nxt;
    logic                 w_pll_ready_nxt;
    logic                 w_reset_fail_nxt;
    logic [NUM_PLL-1:0]   w_lock_sync;
    logic                 w_lock_all;
    logic                 w_holdoff_done;

`ifdef LOCK_SYNC_EN
    gtwizard_lock_sync #(
        .WIDTH   (NUM_PLL)
    ) u_lock_sync (
        .clk     (STABLE_CLOCK),
        .rst     (~SOFT_RESET_N),
        .i_async (PLL_LOCK),
        .o_sync  (w_lock_sync)
    );
`else
    assign w_lock_sync = PLL_LOCK;
`endif

    assign w_lock_all     = &w_lock_sync;
    assign w_holdoff_done = (r_phase_cnt >= c_HOLDOFF_V);
    assign w_retry_inc    = (r_retry_cnt == c_RETRY_SAT) ? r_retry_cnt
                                                         : r_retry_cnt + c_RETRY_W'(1);

    always_ff @(posedge STABLE_CLOCK) begin
        if (!SOFT_RESET_N) begin
            r_state        <= c_INIT_WAIT;
            r_wait_cnt     <= '0;
            r_phase_cnt    <= '0;
            r_retry_cnt    <= '0;
            r_common_reset <= 1'b0;
            r_pll_ready    <= 1'b0;
            r_reset_fail   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_wait_cnt     <= w_wait_cnt_nxt;
            r_phase_cnt    <= w_phase_cnt_nxt;
            r_retry_cnt    <= w_retry_cnt_nxt;
            r_common_reset <= w_common_reset_nxt;
            r_pll_ready    <= w_pll_ready_nxt;
            r_reset_fail   <= w_reset_fail_nxt;
        end
    end

    // Phase counter restarts at zero on every state change.
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_phase_cnt_nxt = '0;
        w_retry_cnt_nxt = r_retry_cnt;
        case (r_state)
            c_INIT_WAIT: begin
                if (r_wait_cnt == c_WAIT_END) begin
                    w_state_nxt = c_ASSERT_RESET;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_WAIT_W'(1);
                end
            end
            c_ASSERT_RESET: begin
                if (r_phase_cnt == c_PULSE_END) begin
                    w_state_nxt = c_WAIT_LOCK;
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt + c_PHASE_W'(1);
                end
            end
            c_WAIT_LOCK: begin
                if (w_holdoff_done && w_lock_all) begin
                    w_state_nxt     = c_READY;
                    w_retry_cnt_nxt = '0;
                end else if (r_phase_cnt == c_TIMEOUT_END) begin
                    w_retry_cnt_nxt = w_retry_inc;
                    w_state_nxt     = (w_retry_inc == c_RETRY_LIMIT) ? c_FAIL : c_ASSERT_RESET;
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt + c_PHASE_W'(1);
                end
            end
            c_READY: begin
                if (!w_lock_all) begin
                    w_state_nxt = c_ASSERT_RESET;
                end
            end
            c_FAIL: begin
                w_state_nxt = c_FAIL;
            end
            default: begin
                w_state_nxt = c_INIT_WAIT;
            end
        endcase
    end

    // Outputs decode the next state so they change on the entry clock.
    always_comb begin
        w_common_reset_nxt = (w_state_nxt == c_ASSERT_RESET) || (w_state_nxt == c_FAIL);
        w_pll_ready_nxt    = (w_state_nxt == c_READY);
        w_reset_fail_nxt   = (w_state_nxt == c_FAIL);
    end

    assign COMMON_RESET = {NUM_PLL{r_common_reset}};
    assign PLL_READY    = r_pll_ready;
    assign RESET_FAIL   = r_reset_fail;
    assign RETRY_COUNT  = r_retry_cnt;

endmodule

`default_nettype wire

// File: tb/tb_gtwizard_common_reset_seq.sv
// ============================================================================
// Module      : tb_gtwizard_common_reset_seq
// Description : Directed self-checking bench for gtwizard_common_reset_seq,
//               default parameters; lock latency follows LOCK_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gtwizard_common_reset_seq;

`ifdef LOCK_SYNC_EN
    localparam int c_LOCK_LAT = 2;
`else
    localparam int c_LOCK_LAT = 0;
`endif
    localparam int c_WAIT_MAX = 72;

    logic       clk          = 1'b0;
    logic       soft_reset_n = 1'b0;
    logic [1:0] pll_lock     = 2'b00;
    logic [1:0] common_reset;
    logic       pll_ready;
    logic       reset_fail;
    logic [3:0] retry_count;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;

    gtwizard_common_reset_seq dut (
        .STABLE_CLOCK (clk),
        .SOFT_RESET_N (soft_reset_n),
        .PLL_LOCK     (pll_lock),
        .COMMON_RESET (common_reset),
        .PLL_READY    (pll_ready),
        .RESET_FAIL   (reset_fail),
        .RETRY_COUNT  (retry_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [1:0] lock);
        pll_lock     = lock;
        soft_reset_n = 1'b0;
        tick(3);
        soft_reset_n = 1'b1;
    endtask

    initial begin
        // Power-on sequence with both PLLs locked
        do_reset(2'b11);
        tick(c_WAIT_MAX);
        check("wait_end_cr", common_reset, 2'b00);
        tick(1);
        check("pulse_start_cr", common_reset, 2'b11);
        tick(3);
        check("pulse_last_cr", common_reset, 2'b11);
        tick(1);
        check("pulse_end_cr", common_reset, 2'b00);
        check("pulse_end_rdy", pll_ready, 1'b0);
        tick(1 + c_LOCK_LAT);
        check("ready_early", pll_ready, 1'b0);
        tick(1);
        check("ready_rise", pll_ready, 1'b1);
        check("ready_retry", retry_count, 4'd0);
        check("ready_fail", reset_fail, 1'b0);

        // One-clock lock glitch on PLL 1 while READY
        pll_lock = 2'b01;
        tick(1);
        pll_lock = 2'b11;
        cycles = 1;
        while (pll_ready && cycles < 20) begin
            tick(1);
            cycles++;
        end
        check("drop_lat", cycles, 1 + c_LOCK_LAT);
        check("drop_cr", common_reset, 2'b11);
        check("drop_retry", retry_count, 4'd0);
        tick(3);
        check("repulse_last", common_reset, 2'b11);
        tick(1);
        check("repulse_end", common_reset, 2'b00);
        cycles = 0;
        while (!pll_ready && cycles < 20) begin
            tick(1);
            cycles++;
        end
        check("relock_lat", cycles, 2 + c_LOCK_LAT);
        check("relock_retry", retry_count, 4'd0);

        // Reset values, then PLL 1 never locks: three retries into FAIL
        do_reset(2'b01);
        check("rst_cr", common_reset, 2'b00);
        check("rst_rdy", pll_ready, 1'b0);
        check("rst_fail", reset_fail, 1'b0);
        check("rst_retry", retry_count, 4'd0);
        tick(c_WAIT_MAX + 1);
        check("p1_cr", common_reset, 2'b11);
        tick(1003);
        check("p1_to_cr", common_reset, 2'b00);
        check("p1_to_retry", retry_count, 4'd0);
        tick(1);
        check("p2_cr", common_reset, 2'b11);
        check("p2_retry", retry_count, 4'd1);
        tick(1003);
        check("p2_to_cr", common_reset, 2'b00);
        tick(1);
        check("p3_cr", common_reset, 2'b11);
        check("p3_retry", retry_count, 4'd2);
        tick(1003);
        check("p3_to_fail", reset_fail, 1'b0);
        tick(1);
        check("fail_retry", retry_count, 4'd3);
        check("fail_flag", reset_fail, 1'b1);
        check("fail_cr", common_reset, 2'b11);
        check("fail_rdy", pll_ready, 1'b0);
        pll_lock = 2'b11;
        tick(50);
        check("fail_hold_flag", reset_fail, 1'b1);
        check("fail_hold_cr", common_reset, 2'b11);

        // Soft reset in the second pulse cycle restarts the full wait
        do_reset(2'b11);
        tick(c_WAIT_MAX + 1);
        tick(1);
        check("mid_pulse_cr", common_reset, 2'b11);
        soft_reset_n = 1'b0;
        tick(1);
        check("mid_rst_cr", common_reset, 2'b00);
        check("mid_rst_fail", reset_fail, 1'b0);
        soft_reset_n = 1'b1;
        tick(c_WAIT_MAX);
        check("rewait_cr", common_reset, 2'b00);
        tick(1);
        check("rewait_pulse", common_reset, 2'b11);

        // Lock first visible on the timeout clock: lock wins
        do_reset(2'b00);
        tick(c_WAIT_MAX + 1 + 4);
        check("to_wl_cr", common_reset, 2'b00);
        tick(999 - c_LOCK_LAT);
        pll_lock = 2'b11;
        tick(c_LOCK_LAT);
        check("to_pre_rdy", pll_ready, 1'b0);
        check("to_pre_cr", common_reset, 2'b00);
        tick(1);
        check("to_lock_rdy", pll_ready, 1'b1);
        check("to_lock_cr", common_reset, 2'b00);
        check("to_lock_retry", retry_count, 4'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
